// File: rtl/subleq_pkg.sv
// Shared types and constants for the subleq bit-serial mux transfer sequencer.
package subleq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } xfer_state_t;

    localparam logic XFER_DIR_READ  = 1'b0;
    localparam logic XFER_DIR_WRITE = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bimux_serial_xfer.sv
// Bit-serial sequencer stepping the subleq 8x1 bidirectional mux through all legs to read or write a word.
// Optional read-parity checking is enabled with the BIMUX_XFER_PARITY_EN macro.
module bimux_serial_xfer
    import subleq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic             mux_dir,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_bit_i,
    output logic             mux_bit_o,
    output logic             mux_bit_oe
`ifdef BIMUX_XFER_PARITY_EN
    ,
    output logic             rparity,
    output logic             perr
`endif
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    xfer_state_t      state_reg, state_next;
    logic [SEL_W-1:0] cnt_reg, cnt_next;
    logic             wr_reg, wr_next;
    logic [WIDTH-1:0] wdata_reg, wdata_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] rdata_reg;

    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             mux_dir_reg, mux_dir_next;
    logic [SEL_W-1:0] mux_sel_reg, mux_sel_next;
    logic             bit_o_reg, bit_o_next;
    logic             oe_reg, oe_next;

    logic             sample_en;
    logic             capture_en;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_next    = wr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    wr_next    = wr;
                    wdata_next = wdata;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_SEL) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with mux_sel.
    always_comb begin
        busy_next    = (state_next != IDLE);
        done_next    = (state_next == DONE);
        mux_sel_next = '0;
        mux_dir_next = XFER_DIR_READ;
        oe_next      = 1'b0;
        bit_o_next   = 1'b0;
        if (state_next == SHIFT) begin
            mux_sel_next = cnt_next;
            mux_dir_next = wr_next;
            oe_next      = (wr_next == XFER_DIR_WRITE);
            bit_o_next   = (wr_next == XFER_DIR_WRITE) ? wdata_next[cnt_next] : 1'b0;
        end
    end

    assign sample_en  = (state_reg == SHIFT) && (wr_reg == XFER_DIR_READ);
    assign capture_en = sample_en && (state_next == DONE);

    // The final bit is folded in combinationally so rdata is already valid in the done cycle.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        assign shift_next[gi] = (sample_en && (cnt_reg == SEL_W'(gi))) ? mux_bit_i : shift_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            wr_reg      <= XFER_DIR_READ;
            wdata_reg   <= '0;
            shift_reg   <= '0;
            rdata_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            mux_dir_reg <= XFER_DIR_READ;
            mux_sel_reg <= '0;
            bit_o_reg   <= 1'b0;
            oe_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wr_reg      <= wr_next;
            wdata_reg   <= wdata_next;
            shift_reg   <= shift_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            mux_dir_reg <= mux_dir_next;
            mux_sel_reg <= mux_sel_next;
            bit_o_reg   <= bit_o_next;
            oe_reg      <= oe_next;
            if (capture_en) begin
                rdata_reg <= shift_next;
            end
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign rdata      = rdata_reg;
    assign mux_dir    = mux_dir_reg;
    assign mux_sel    = mux_sel_reg;
    assign mux_bit_o  = bit_o_reg;
    assign mux_bit_oe = oe_reg;

`ifdef BIMUX_XFER_PARITY_EN
    logic rparity_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rparity_reg <= 1'b0;
        end else if (capture_en) begin
            rparity_reg <= ^shift_next;
        end
    end

    // The sender parks its parity bit on leg 0 while the mux is back at sel=0 in the done cycle.
    assign rparity = rparity_reg;
    assign perr    = done_reg && (rparity_reg != mux_bit_i);
`endif

endmodule

// File: tb/tb_bimux_serial_xfer.sv
// Scoreboard bench for bimux_serial_xfer: an acceptance/timing model queues transactions, a monitor checks every cycle.
module tb_bimux_serial_xfer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         wr = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, mux_dir, mux_bit_i, mux_bit_o, mux_bit_oe;
    logic [W-1:0] rdata;
    logic [2:0]   mux_sel;
    logic [W-1:0] legs = '0;
    logic         par_bit = 1'b0;
    logic         rparity_obs, perr_obs;

    always #5 clk = ~clk;

    bimux_serial_xfer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .wr         (wr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .mux_dir    (mux_dir),
        .mux_sel    (mux_sel),
        .mux_bit_i  (mux_bit_i),
        .mux_bit_o  (mux_bit_o),
        .mux_bit_oe (mux_bit_oe)
`ifdef BIMUX_XFER_PARITY_EN
        ,
        .rparity    (rparity_obs),
        .perr       (perr_obs)
`endif
    );

`ifndef BIMUX_XFER_PARITY_EN
    assign rparity_obs = 1'b0;
    assign perr_obs    = 1'b0;
`endif

    // Mux environment: legs feed the common line in read direction; sender puts parity there during done.
    assign mux_bit_i = (mux_dir == 1'b0) ? (done ? par_bit : legs[mux_sel]) : mux_bit_o;

    typedef struct packed {
        int           a;
        logic         wr;
        logic [W-1:0] wdata;
        logic [W-1:0] legs;
    } txn_t;

    txn_t q[$];
    int   e = 0;
    int   next_ok = 0;
    bit   last_rst = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   dones = 0;

    // Acceptance model: a start is taken at an edge only if the previous transaction has fully retired.
    always @(posedge clk) begin
        e = e + 1;
        if (!rst_n) begin
            q.delete();
            next_ok  = e + 1;
            last_rst = 1'b1;
        end else begin
            last_rst = 1'b0;
            if (start && e >= next_ok) begin
                q.push_back('{a: e, wr: wr, wdata: wdata, legs: legs});
                next_ok = e + W + 2;
            end
        end
    end

    logic [W-1:0] vis = '0;
    logic         vis_par = 1'b0;
    logic [17:0]  exp_v, act_v;
    logic         x_busy, x_done, x_dir, x_oe, x_bo, x_perr;
    logic [2:0]   x_sel;
    int           d;

    always @(negedge clk) begin
        if (e > 0) begin
            x_busy = 1'b0; x_done = 1'b0; x_dir = 1'b0; x_oe = 1'b0; x_bo = 1'b0;
            x_perr = 1'b0; x_sel = 3'd0;
            if (last_rst) begin
                vis     = '0;
                vis_par = 1'b0;
            end
            if (q.size() > 0) begin
                d = e - q[0].a + 1;
                x_busy = 1'b1;
                if (d <= W) begin
                    x_sel = 3'(d - 1);
                    x_dir = q[0].wr;
                    x_oe  = q[0].wr;
                    x_bo  = q[0].wr & q[0].wdata[d-1];
                end else begin
                    x_done = 1'b1;
                    if (!q[0].wr) begin
                        vis     = q[0].legs;
                        vis_par = ^q[0].legs;
                    end
                    x_perr = vis_par ^ par_bit;
                    void'(q.pop_front());
                    dones++;
                end
            end
`ifdef BIMUX_XFER_PARITY_EN
            exp_v = {x_busy, x_done, x_dir, x_sel, x_oe, x_bo, vis, vis_par, x_perr};
`else
            exp_v = {x_busy, x_done, x_dir, x_sel, x_oe, x_bo, vis, 1'b0, 1'b0};
`endif
            act_v = {busy, done, mux_dir, mux_sel, mux_bit_oe, mux_bit_o, rdata, rparity_obs, perr_obs};
            checks++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL outputs edge %0d {busy,done,dir,sel,oe,bit_o,rdata,rpar,perr}: got %b_%b_%b_%0d_%b_%b_%h_%b_%b required %b_%b_%b_%0d_%b_%b_%h_%b_%b",
                         e, act_v[17], act_v[16], act_v[15], act_v[14:12], act_v[11], act_v[10], act_v[9:2], act_v[1], act_v[0],
                         exp_v[17], exp_v[16], exp_v[15], exp_v[14:12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One start pulse, then W+1 cycles where start may be spammed with changing wr/wdata that must be ignored.
    task automatic xfer(input logic w, input logic [W-1:0] dat, input logic [W-1:0] l,
                        input logic p, input bit noise);
        legs    = l;
        par_bit = p;
        wr      = w;
        wdata   = dat;
        start   = 1'b1;
        cyc();
        for (int i = 0; i < W + 1; i++) begin
            start = noise ? 1'($urandom % 2) : 1'b0;
            wr    = 1'($urandom % 2);
            wdata = W'($urandom);
            cyc();
        end
        start = 1'b0;
        $display("xfer wr=%0d wdata=%h legs=%h par=%0d noise=%0d", w, dat, l, p, noise);
    endtask

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        xfer(1'b0, 8'h00, 8'hA5, 1'b0, 1'b0);
        xfer(1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1);
        xfer(1'b0, 8'h00, 8'h07, 1'b0, 1'b0);

        legs    = W'($urandom);
        par_bit = 1'($urandom % 2);
        for (int i = 0; i < 40; i++) begin
            start = 1'b1;
            wr    = 1'($urandom % 2);
            wdata = W'($urandom);
            cyc();
        end
        start = 1'b0;
        $display("back-to-back burst of 40 start cycles, legs=%h", legs);
        repeat (W + 2) cyc();

        legs  = 8'h5A;
        wr    = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        $display("abort read at bit 4");
        cyc();
        xfer(1'b0, 8'h00, 8'hC3, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            xfer(1'($urandom % 2), W'($urandom), W'($urandom), 1'($urandom % 2), 1'($urandom % 2));
            repeat ($urandom_range(0, 3)) cyc();
        end

        repeat (W + 4) cyc();
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d transactions outstanding required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
